// File: rtl/csi_tx_packetizer.sv
// CSI-2 two-lane packet transmitter: turns FS/FE/LINE commands plus a pixel-byte
// stream into sync, ECC-protected header, payload and CRC footer words.
module csi_tx_packetizer #(
    parameter int         GAP_CYCLES = 8,
    parameter logic [1:0] VC         = 2'd0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    input  logic [1:0]  cmd_type,
    input  logic [5:0]  cfg_dt,
    input  logic [15:0] cfg_wc,
    input  logic [15:0] pix_dat,
    input  logic        pix_vld,
    output logic        pix_rdy,
    output logic [15:0] tx_dat,
    output logic        tx_vld,
    output logic        tx_hs,
    output logic        err_underrun,
    output logic [2:0]  state_dbg
);

    // Handshakes: a command moves on a clock edge where cmd_vld & cmd_rdy, a payload
    // word where pix_vld & pix_rdy; ready never depends on the matching valid.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_HDR0    = 3'd2,
        S_HDR1    = 3'd3,
        S_PAYLOAD = 3'd4,
        S_CRC     = 3'd5,
        S_GAP     = 3'd6
    } state_t;

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    function automatic logic [7:0] ecc_calc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = (^d[19:10])^d[21]^d[22]^d[23];
        return {2'b00, p};
    endfunction

    // Reflected CRC-16 (x^16+x^12+x^5+1), one byte fed LSB first.
    function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] b);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 16'h8408;
            else             c = c >> 1;
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  di_q, di_d;
    logic [15:0] wc_q, wc_d;
    logic        short_q, short_d;
    logic [15:0] frame_q, frame_d;
    logic [15:0] crc_q, crc_d;
    logic        err_q, err_d;

    logic        accept;
    logic [15:0] frame_inc;
    logic        cfg_wc_unused;

    assign cfg_wc_unused = cfg_wc[0];
    assign err_underrun  = err_q;
    assign state_dbg     = state_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        di_d      = di_q;
        wc_d      = wc_q;
        short_d   = short_q;
        frame_d   = frame_q;
        crc_d     = crc_q;
        err_d     = err_q;
        pix_rdy   = 1'b0;
        tx_dat    = 16'h0000;
        tx_vld    = 1'b0;
        tx_hs     = 1'b0;
        cmd_rdy   = (state_q == S_IDLE) & enable & reset_n;
        accept    = cmd_vld & cmd_rdy;
        frame_inc = (frame_q == 16'hFFFF) ? 16'h0001 : frame_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    crc_d = 16'hFFFF;
                    cnt_d = 16'd0;
                    case (cmd_type)
                        2'd0: begin
                            frame_d = frame_inc;
                            wc_d    = frame_inc;
                            di_d    = {VC, 6'h00};
                            short_d = 1'b1;
                            state_d = S_SYNC;
                        end
                        2'd1: begin
                            wc_d    = frame_q;
                            di_d    = {VC, 6'h01};
                            short_d = 1'b1;
                            state_d = S_SYNC;
                        end
                        2'd2: begin
                            wc_d    = {cfg_wc[15:1], 1'b0};
                            di_d    = {VC, cfg_dt};
                            short_d = 1'b0;
                            state_d = S_SYNC;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_SYNC: begin
                tx_vld  = 1'b1;
                tx_hs   = 1'b1;
                tx_dat  = 16'hB8B8;
                state_d = S_HDR0;
            end
            S_HDR0: begin
                tx_vld  = 1'b1;
                tx_hs   = 1'b1;
                tx_dat  = {wc_q[7:0], di_q};
                state_d = S_HDR1;
            end
            S_HDR1: begin
                tx_vld = 1'b1;
                tx_hs  = 1'b1;
                tx_dat = {ecc_calc({wc_q, di_q}), wc_q[15:8]};
                cnt_d  = 16'd0;
                if (short_q) begin
                    state_d = S_GAP;
                end else if (wc_q == 16'd0) begin
                    state_d = S_CRC;
                end else begin
                    cnt_d   = {1'b0, wc_q[15:1]};
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                tx_hs   = 1'b1;
                pix_rdy = 1'b1;
                if (pix_vld) begin
                    tx_vld = 1'b1;
                    tx_dat = pix_dat;
                    crc_d  = crc_byte(crc_byte(crc_q, pix_dat[7:0]), pix_dat[15:8]);
                    cnt_d  = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_d = S_CRC;
                end else begin
                    err_d = 1'b1;
                end
            end
            S_CRC: begin
                tx_vld  = 1'b1;
                tx_hs   = 1'b1;
                tx_dat  = crc_q;
                cnt_d   = 16'd0;
                state_d = S_GAP;
            end
            S_GAP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            di_q    <= 8'd0;
            wc_q    <= 16'd0;
            short_q <= 1'b0;
            frame_q <= 16'd0;
            crc_q   <= 16'hFFFF;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            di_q    <= di_d;
            wc_q    <= wc_d;
            short_q <= short_d;
            frame_q <= frame_d;
            crc_q   <= crc_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_csi_tx_packetizer.sv
// Directed + randomized bench for csi_tx_packetizer with a packet-level reference model.
module tb_csi_tx_packetizer;
    localparam int GAP = 8;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [1:0]  cmd_type;
    logic [5:0]  cfg_dt;
    logic [15:0] cfg_wc;
    logic [15:0] pix_dat;
    logic        pix_vld;
    logic        pix_rdy;
    logic [15:0] tx_dat;
    logic        tx_vld;
    logic        tx_hs;
    logic        err_underrun;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    logic [15:0] pay_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    logic [15:0] m_frame;
    int          rel, end_rel, ready_rel;
    int          stall_at, stall_len, stall_seen, rdy_pulses;
    bit          misc_bad, done_flag;
    logic [15:0] known_w[12] = '{16'h00FF, 16'h0200, 16'hDCB9, 16'h72F3, 16'hD4BB, 16'h5AB8,
                                 16'h75C8, 16'h7CC2, 16'hF881, 16'hDF05, 16'h00FF, 16'h0100};

    csi_tx_packetizer #(.GAP_CYCLES(GAP), .VC(2'd0)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_type(cmd_type),
        .cfg_dt(cfg_dt), .cfg_wc(cfg_wc),
        .pix_dat(pix_dat), .pix_vld(pix_vld), .pix_rdy(pix_rdy),
        .tx_dat(tx_dat), .tx_vld(tx_vld), .tx_hs(tx_hs),
        .err_underrun(err_underrun), .state_dbg(state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int expv);
        checks++;
        assert (obs == expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Header ECC from the parity bit lists of the CSI-2 Hamming code.
    function automatic logic [7:0] ecc_model(input logic [23:0] d);
        int l0[14] = '{0, 1, 2, 4, 5, 7, 10, 11, 13, 16, 20, 21, 22, 23};
        int l1[14] = '{0, 1, 3, 4, 6, 8, 10, 12, 14, 17, 20, 21, 22, 23};
        int l2[13] = '{0, 2, 3, 5, 6, 9, 11, 12, 15, 18, 20, 21, 22};
        int l3[13] = '{1, 2, 3, 7, 8, 9, 13, 14, 15, 19, 20, 21, 23};
        int l4[13] = '{4, 5, 6, 7, 8, 9, 16, 17, 18, 19, 20, 22, 23};
        int l5[13] = '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 21, 22, 23};
        logic [7:0] e;
        e = 8'h00;
        foreach (l0[i]) e[0] = e[0] ^ d[l0[i]];
        foreach (l1[i]) e[1] = e[1] ^ d[l1[i]];
        foreach (l2[i]) e[2] = e[2] ^ d[l2[i]];
        foreach (l3[i]) e[3] = e[3] ^ d[l3[i]];
        foreach (l4[i]) e[4] = e[4] ^ d[l4[i]];
        foreach (l5[i]) e[5] = e[5] ^ d[l5[i]];
        return e;
    endfunction

    function automatic logic [15:0] crc_model(input logic [15:0] crc_in, input logic [7:0] b);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 16'h8408;
            else             c = c >> 1;
        end
        return c;
    endfunction

    task automatic build_exp(input logic [1:0] typ, input logic [5:0] dt, input logic [15:0] wc_in);
        logic [15:0] wc;
        logic [7:0]  di;
        logic [15:0] crc;
        exp_q.delete();
        wc = 16'h0000;
        di = 8'h00;
        if (typ == 2'd0) begin
            m_frame = (m_frame == 16'hFFFF) ? 16'h0001 : m_frame + 16'd1;
            wc = m_frame;
            di = 8'h00;
        end else if (typ == 2'd1) begin
            wc = m_frame;
            di = 8'h01;
        end else if (typ == 2'd2) begin
            wc = wc_in & 16'hFFFE;
            di = {2'b00, dt};
        end
        if (typ != 2'd3) begin
            exp_q.push_back(16'hB8B8);
            exp_q.push_back({wc[7:0], di});
            exp_q.push_back({ecc_model({wc, di}), wc[15:8]});
        end
        if (typ == 2'd2) begin
            crc = 16'hFFFF;
            foreach (pay_q[i]) begin
                exp_q.push_back(pay_q[i]);
                crc = crc_model(crc, pay_q[i][7:0]);
                crc = crc_model(crc, pay_q[i][15:8]);
            end
            exp_q.push_back(crc);
        end
    endtask

    task automatic send_cmd(input string tag, input logic [1:0] typ, input logic [5:0] dt,
                            input logic [15:0] wc);
        int w;
        w = 0;
        while (!cmd_rdy && w < 100) begin
            tick();
            w++;
        end
        chk1({tag, "_cmd_rdy"}, cmd_rdy, 1'b1);
        cmd_type = typ;
        cfg_dt   = dt;
        cfg_wc   = wc;
        cmd_vld  = 1'b1;
        tick();
        cmd_vld  = 1'b0;
        rel      = 1;
    endtask

    // Drives payload (with an optional stall before word stall_at) and gathers valid words.
    task automatic run_packet(input int budget);
        int widx;
        int stall_left;
        bit seen_hs;
        widx = 0;
        stall_left = stall_len;
        seen_hs = 0;
        done_flag = 0;
        misc_bad = 0;
        stall_seen = 0;
        rdy_pulses = 0;
        end_rel = -1;
        obs_q.delete();
        while (!done_flag && rel < budget) begin
            pix_vld = 1'b0;
            pix_dat = 16'h0000;
            if (pix_rdy) begin
                if (widx == stall_at && stall_left > 0) stall_left--;
                else if (pay_q.size() > 0) begin
                    pix_vld = 1'b1;
                    pix_dat = pay_q[0];
                end
            end
            #1;
            if (tx_hs) seen_hs = 1;
            if (tx_vld) begin
                obs_q.push_back(tx_dat);
                if (!tx_hs) misc_bad = 1;
            end else if (tx_dat !== 16'h0000) begin
                misc_bad = 1;
            end
            if (pix_rdy) rdy_pulses++;
            if (pix_rdy && !tx_vld && tx_hs) stall_seen++;
            if (pix_rdy && pix_vld) begin
                void'(pay_q.pop_front());
                widx++;
            end
            if (seen_hs && !tx_hs) begin
                done_flag = 1;
                end_rel = rel;
            end
            @(posedge clock);
            #1;
            rel++;
        end
        pix_vld = 1'b0;
        pix_dat = 16'h0000;
    endtask

    task automatic compare_words(input string tag);
        chki({tag, "_nwords"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk16($sformatf("%s_w%0d", tag, i), obs_q[i], exp_q[i]);
    endtask

    function automatic logic [15:0] obs_at(input int i);
        if (i >= 0 && i < obs_q.size()) return obs_q[i];
        return 16'hxxxx;
    endfunction

    task automatic wait_ready(input int budget);
        while (!cmd_rdy && rel < budget) begin
            #1;
            if (tx_vld || tx_hs) misc_bad = 1;
            @(posedge clock);
            #1;
            rel++;
        end
        ready_rel = cmd_rdy ? rel : -1;
    endtask

    task automatic do_packet(input string tag, input logic [1:0] typ, input logic [5:0] dt,
                             input logic [15:0] wc);
        int nw;
        int exp_end;
        nw = pay_q.size();
        build_exp(typ, dt, wc);
        exp_end = 4;
        if (typ == 2'd2) exp_end = 4 + nw + 1 + ((stall_at < nw) ? stall_len : 0);
        send_cmd(tag, typ, dt, wc);
        run_packet(300);
        compare_words(tag);
        chki({tag, "_end_cycle"}, end_rel, exp_end);
        wait_ready(400);
        chki({tag, "_rdy_cycle"}, ready_rel, exp_end + GAP);
        chk1({tag, "_framing"}, misc_bad, 1'b0);
    endtask

    task automatic fill_random(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(16'($urandom));
    endtask

    task automatic fill_known();
        pay_q.delete();
        foreach (known_w[i]) pay_q.push_back(known_w[i]);
    endtask

    initial begin
        int nw;
        logic [15:0] wc_r;
        bit bad;
        reset_n = 1'b0; enable = 1'b1; cmd_vld = 1'b0; cmd_type = 2'd0;
        cfg_dt = 6'd0; cfg_wc = 16'd0; pix_dat = 16'd0; pix_vld = 1'b0;
        stall_at = 1000; stall_len = 0; m_frame = 16'h0000;

        tick(); tick(); tick();
        chk1("rst_cmd_rdy", cmd_rdy, 1'b0);
        chk1("rst_pix_rdy", pix_rdy, 1'b0);
        chk1("rst_tx_vld", tx_vld, 1'b0);
        chk1("rst_tx_hs", tx_hs, 1'b0);
        chk16("rst_tx_dat", tx_dat, 16'h0000);
        chk1("rst_err", err_underrun, 1'b0);
        chk16("rst_state", 16'(state_dbg), 16'h0000);
        reset_n = 1'b1;
        tick();
        chk1("idle_cmd_rdy", cmd_rdy, 1'b1);

        pay_q.delete();
        do_packet("fs1", 2'd0, 6'd0, 16'd0);
        chk16("fs1_hdr0_lit", obs_at(1), 16'h0100);
        chk16("fs1_hdr1_lit", obs_at(2), 16'h1A00);
        do_packet("fe1", 2'd1, 6'd0, 16'd0);
        chk16("fe1_hdr0_lit", obs_at(1), 16'h0101);

        send_cmd("rsv", 2'd3, 6'd0, 16'd0);
        chk1("rsv_rdy_next", cmd_rdy, 1'b1);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (tx_vld || tx_hs || pix_rdy) bad = 1;
            tick();
        end
        chk1("rsv_silent", bad, 1'b0);

        force dut.frame_q = 16'hFFFE;
        #2;
        release dut.frame_q;
        m_frame = 16'hFFFE;
        tick();
        do_packet("fs_ffff", 2'd0, 6'd0, 16'd0);
        chk16("fs_ffff_hdr0_lit", obs_at(1), 16'hFF00);
        do_packet("fs_wrap", 2'd0, 6'd0, 16'd0);
        chk16("fs_wrap_hdr0_lit", obs_at(1), 16'h0100);
        chk16("fs_wrap_hdr1_lit", obs_at(2), 16'h1A00);
        do_packet("fe_wrap", 2'd1, 6'd0, 16'd0);
        chk16("fe_wrap_hdr0_lit", obs_at(1), 16'h0101);

        fill_known();
        do_packet("line24", 2'd2, 6'h2B, 16'd24);
        chk16("line24_crc_lit", obs_at(obs_q.size() - 1), 16'h00F0);
        chk1("line24_no_err", err_underrun, 1'b0);

        pay_q.delete();
        do_packet("line0", 2'd2, 6'h2B, 16'd0);
        chk16("line0_crc_lit", obs_at(3), 16'hFFFF);
        chki("line0_no_pix_rdy", rdy_pulses, 0);

        fill_random(12);
        do_packet("line25", 2'd2, 6'h1E, 16'd25);
        chk16("line25_hdr0_lit", obs_at(1), 16'h181E);

        fill_known();
        stall_at = 5; stall_len = 3;
        do_packet("stall", 2'd2, 6'h2B, 16'd24);
        chki("stall_cycles", stall_seen, 3);
        chk16("stall_crc_lit", obs_at(obs_q.size() - 1), 16'h00F0);
        chk1("stall_err_set", err_underrun, 1'b1);

        for (int k = 0; k < 4; k++) begin
            nw = $urandom_range(1, 20);
            fill_random(nw);
            wc_r = 16'(2 * nw + $urandom_range(0, 1));
            stall_at = $urandom_range(0, nw - 1);
            stall_len = $urandom_range(0, 3);
            do_packet($sformatf("rnd%0d", k), 2'd2, 6'($urandom_range(0, 63)), wc_r);
        end
        stall_at = 1000; stall_len = 0;
        chk1("err_sticky", err_underrun, 1'b1);

        pay_q.delete();
        build_exp(2'd0, 6'd0, 16'd0);
        send_cmd("en_drop", 2'd0, 6'd0, 16'd0);
        enable = 1'b0;
        run_packet(300);
        compare_words("en_drop");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_rdy || tx_vld || tx_hs) bad = 1;
            tick();
        end
        chk1("en_drop_hold", bad, 1'b0);
        enable = 1'b1;
        #1;
        chk1("en_restore_rdy", cmd_rdy, 1'b1);

        fill_random(10);
        send_cmd("rst_mid", 2'd2, 6'h2A, 16'd20);
        tick(); tick(); tick();
        chk1("rst_mid_in_payload", pix_rdy, 1'b1);
        pix_vld = 1'b1;
        pix_dat = pay_q[0];
        tick();
        pix_dat = pay_q[1];
        tick();
        reset_n = 1'b0;
        tick();
        chk1("rst_mid_tx_vld", tx_vld, 1'b0);
        chk1("rst_mid_tx_hs", tx_hs, 1'b0);
        chk16("rst_mid_tx_dat", tx_dat, 16'h0000);
        chk1("rst_mid_pix_rdy", pix_rdy, 1'b0);
        chk1("rst_mid_cmd_rdy", cmd_rdy, 1'b0);
        chk1("rst_mid_err", err_underrun, 1'b0);
        chk16("rst_mid_state", 16'(state_dbg), 16'h0000);
        reset_n = 1'b1;
        pix_vld = 1'b0;
        pix_dat = 16'h0000;
        m_frame = 16'h0000;
        tick();
        pay_q.delete();
        do_packet("fs_after_rst", 2'd0, 6'd0, 16'd0);
        chk16("fs_after_rst_hdr0_lit", obs_at(1), 16'h0100);
        chk16("fs_after_rst_hdr1_lit", obs_at(2), 16'h1A00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csi_tx_packetizer.md
# csi_tx_packetizer

CSI-2 packet transmitter for a 2-lane link, running in the byte-clock domain. It builds Frame Start, Frame End and long line packets from commands plus a pixel-byte stream. Each packet is sent as a per-lane sync byte, a header with ECC, an optional payload and a CRC footer, striped across lanes in the layout the CSI receive path depacketizes. It sits between the test-pattern/video source and the lane serializers, and serves as loopback stimulus for the receive path.

## Interface
- GAP_CYCLES, 8: idle (LP-emulation) cycles forced after every packet, ≥1.
- VC, 2'd0: virtual channel placed in DI[7:6].
- clock  in  1  byte clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  when 0, no new command is accepted; a packet in flight completes.
- cmd_vld  in  1  command valid.
- cmd_rdy  out  1  command ready; a command transfers when cmd_vld & cmd_rdy.
- cmd_type  in  2  0=FS, 1=FE, 2=LINE, 3=reserved (accepted, dropped, no output).
- cfg_dt  in  6  data type for LINE, sampled at accept.
- cfg_wc  in  16  LINE payload byte count, sampled at accept; bit 0 is forced to 0.
- pix_dat  in  16  two payload bytes; [7:0] is the earlier byte.
- pix_vld  in  1  payload word valid.
- pix_rdy  out  1  payload word ready.
- tx_dat  out  16  lane word; [7:0]=lane 0, [15:8]=lane 1.
- tx_vld  out  1  tx_dat valid.
- tx_hs  out  1  HS request, high from the sync word through the last footer/header word.
- err_underrun  out  1  sticky; set when pix_vld=0 in PAYLOAD; cleared only by reset.

## Operation
- Byte striping: packet byte n goes to lane n mod 2. Word k carries bytes 2k (low) and 2k+1 (high).
- **FSM states:** IDLE, SYNC, HDR0, HDR1, PAYLOAD, CRC, GAP.
- **Transitions:**
  - IDLE→SYNC on accept. Reserved cmd_type stays in IDLE.
  - SYNC→HDR0→HDR1.
  - HDR1→GAP for FS or FE.
  - HDR1→PAYLOAD for LINE with wc≠0, or HDR1→CRC for LINE with wc=0.
  - PAYLOAD→CRC after wc/2 accepted words.
  - CRC→GAP.
  - GAP→IDLE after GAP_CYCLES cycles.
- **Word contents:**
  - SYNC: tx_dat=16'hB8B8.
  - HDR0: {WC[7:0], DI}.
  - HDR1: {ECC, WC[15:8]}.
- **DI:** {VC, dt}. dt is 6'h00 for FS, 6'h01 for FE, and cfg_dt for LINE.
- **WC field:**
  - FS and FE carry the 16-bit frame number.
  - LINE carries wc.
- **Frame number:**
  - Resets to 0.
  - Incremented before each FS is emitted; 0xFFFF wraps to 0x0001, skipping 0.
  - FE carries the current value.
- **ECC:** CSI-2 6-bit Hamming over D[23:0]={WC hi, WC lo, DI}. ECC[7:6]=0. Parity bits:
  - P0=D0^D1^D2^D4^D5^D7^D10^D11^D13^D16^D20^D21^D22^D23
  - P1=D0^D1^D3^D4^D6^D8^D10^D12^D14^D17^D20^D21^D22^D23
  - P2=D0^D2^D3^D5^D6^D9^D11^D12^D15^D18^D20^D21^D22
  - P3=D1^D2^D3^D7^D8^D9^D13^D14^D15^D19^D20^D21^D23
  - P4=D4^D5^D6^D7^D8^D9^D16^D17^D18^D19^D20^D22^D23
  - P5=D10..D19^D21^D22^D23
- **CRC:** CRC-16, polynomial x^16+x^12+x^5+1, init 0xFFFF, bytes LSB-first.
  - Updated by two bytes per accepted payload word, low byte first.
  - CRC word = {crc[15:8], crc[7:0]}.
  - wc=0 yields 0xFFFF.
- **Payload:**
  - pix_rdy=1 only in PAYLOAD. Each handshake forwards pix_dat to tx_dat unchanged and counts one word.
  - pix_vld=0 in PAYLOAD: tx_vld=0 that cycle, state held, tx_hs stays 1, err_underrun set.
- enable drop mid-packet: the packet and its GAP complete; cmd_rdy stays 0 afterwards.
- reset_n=0 mid-packet: next edge forces IDLE, clears counters and outputs, and resets frame number to 0.

## Timing
- **Reset values:**
  - cmd_rdy=0, pix_rdy=0, tx_vld=0, tx_hs=0.
  - tx_dat=0, err_underrun=0.
  - Frame number=0.
- cmd_rdy = (state==IDLE) & enable & reset_n, registered-state decode with no combinational path from cmd_vld.
- Accept on edge N: SYNC word is on tx_dat with tx_vld=1 and tx_hs=1 during cycle N+1. HDR0 follows at N+2, HDR1 at N+3.
- **Short packet:** 3 valid words, then tx_vld=0 and tx_hs=0 for GAP_CYCLES cycles. The next cmd_rdy comes at N+4+GAP_CYCLES.
- **LINE, no stall:** payload word i appears on tx_dat in the cycle it is accepted (pix_rdy combinational from state). Payload occupies cycles N+4 .. N+3+wc/2; CRC word follows the next cycle.
- tx_dat outside valid cycles is 16'h0000.

## Test plan
- Reset, then FS command → words B8B8, 0x0100, 0x1A00; frame number 1; 8 idle cycles; cmd_rdy returns at N+12.
- FS then FE, with frame number preset via 0xFFFF FS commands → FS after 0xFFFF carries 0x0001 (wrap skips 0); FE repeats the same number.
- LINE, cfg_dt=0x2B, cfg_wc=24, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 → 12 payload words unchanged, then CRC word 0x00F0.
- LINE with cfg_wc=0 → header, then footer 0xFFFF, no pix_rdy pulses; cfg_wc=25 behaves as 24.
- LINE with pix_vld low for 3 cycles mid-payload → tx_vld low for 3 cycles, tx_hs high, err_underrun=1 and sticky; CRC unchanged versus the unstalled run.
- reset_n low during PAYLOAD → next cycle all outputs 0, state IDLE; a new FS after release carries frame number 1.
